// File: rtl/register_file.sv
// Architectural register bank: write-back commit, two combinational read ports
// with same-cycle write bypass, and a valid/ready dump engine for the debug unit.
module register_file #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 5,
  parameter int unsigned NB_REG  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic [NB_ADDR-1:0] i_reg2write,
  input  logic               i_regWrite,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic [NB_ADDR-1:0] o_dump_idx,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

  localparam logic [NB_ADDR-1:0] LastIdx = NB_ADDR'(NB_REG - 1);

  logic [NB_DATA-1:0] regs_q [NB_REG];
  logic [NB_DATA-1:0] regs_d [NB_REG];
  logic               wr_en;

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] dump_idx_q, dump_idx_d;
  logic [NB_DATA-1:0] dump_data_q, dump_data_d;
  logic               dump_valid_q, dump_valid_d;
  logic               dump_busy_q, dump_busy_d;
  logic               dump_done_q, dump_done_d;
  logic [NB_ADDR-1:0] next_idx;

  // Register 0 is hardwired to zero, so writes to it are dropped here.
  assign wr_en    = i_regWrite && (i_reg2write != '0);
  assign next_idx = dump_idx_q + NB_ADDR'(1);

  // Next-state of the bank: regs_d already carries this cycle's write, which
  // doubles as the bypass source for the dump beat loaded at this edge.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[i_reg2write] = i_write_data;
    end
  end

  // Commit the write-back at the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NB_REG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero for r0, bypass when the same index is being written.
  always_comb begin
    o_rs_data = regs_q[i_rs_addr];
    if (wr_en && (i_reg2write == i_rs_addr)) begin
      o_rs_data = i_write_data;
    end
    if (i_rs_addr == '0) begin
      o_rs_data = '0;
    end
    o_rt_data = regs_q[i_rt_addr];
    if (wr_en && (i_reg2write == i_rt_addr)) begin
      o_rt_data = i_write_data;
    end
    if (i_rt_addr == '0) begin
      o_rt_data = '0;
    end
  end

  // Dump engine next-state; the held beat only changes on a handshake.
  always_comb begin
    state_d      = state_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    dump_valid_d = dump_valid_q;
    dump_busy_d  = dump_busy_q;
    dump_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_dump_start) begin
          state_d      = StSend;
          dump_idx_d   = '0;
          dump_data_d  = '0;
          dump_valid_d = 1'b1;
          dump_busy_d  = 1'b1;
        end
      end
      StSend: begin
        if (i_dump_ready) begin
          if (dump_idx_q == LastIdx) begin
            state_d      = StDone;
            dump_valid_d = 1'b0;
            dump_busy_d  = 1'b0;
            dump_done_d  = 1'b1;
          end else begin
            dump_idx_d  = next_idx;
            dump_data_d = regs_d[next_idx];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d      = StIdle;
        dump_valid_d = 1'b0;
        dump_busy_d  = 1'b0;
      end
    endcase
  end

  // Dump engine state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_busy_q  <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      dump_busy_q  <= dump_busy_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign o_dump_valid = dump_valid_q;
  assign o_dump_data  = dump_data_q;
  assign o_dump_idx   = dump_idx_q;
  assign o_dump_busy  = dump_busy_q;
  assign o_dump_done  = dump_done_q;

endmodule

// File: tb/tb_register_file.sv
// Randomised bench for register_file against an array-based reference model,
// with directed bypass, r0, full dump, backpressure and mid-dump reset cases.
module tb_register_file;
  localparam int unsigned NbData = 32;
  localparam int unsigned NbAddr = 5;
  localparam int unsigned NbReg  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NbAddr-1:0] rs_addr, rt_addr, wa;
  logic [NbData-1:0] rs_data, rt_data, wd;
  logic              we, start, ready;
  logic              dump_valid, dump_busy, dump_done;
  logic [NbData-1:0] dump_data;
  logic [NbAddr-1:0] dump_idx;

  always #5 clk = ~clk;

  register_file #(
    .NB_DATA(NbData),
    .NB_ADDR(NbAddr),
    .NB_REG (NbReg)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rs_addr   (rs_addr),
    .i_rt_addr   (rt_addr),
    .o_rs_data   (rs_data),
    .o_rt_data   (rt_data),
    .i_write_data(wd),
    .i_reg2write (wa),
    .i_regWrite  (we),
    .i_dump_start(start),
    .i_dump_ready(ready),
    .o_dump_valid(dump_valid),
    .o_dump_data (dump_data),
    .o_dump_idx  (dump_idx),
    .o_dump_busy (dump_busy),
    .o_dump_done (dump_done)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: plain register array plus the beat currently presented.
  logic [NbData-1:0] m_regs [NbReg];
  bit                m_valid, m_done;
  int                m_idx;
  logic [NbData-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NbData-1:0] m_read(input logic [NbAddr-1:0] a);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NbReg; i++) m_regs[i] = '0;
    m_valid = 0;
    m_done  = 0;
    m_idx   = 0;
    m_data  = '0;
  endtask

  // Effect of one rising edge on the model, using the inputs currently driven.
  task automatic model_edge();
    if (we && wa != 0) m_regs[wa] = wd;
    if (m_done) begin
      m_done = 0;
    end else if (m_valid) begin
      if (ready) begin
        if (m_idx == NbReg - 1) begin
          m_valid = 0;
          m_done  = 1;
        end else begin
          m_idx++;
          m_data = m_regs[m_idx];
        end
      end
    end else if (start) begin
      m_valid = 1;
      m_idx   = 0;
      m_data  = '0;
    end
  endtask

  task automatic check_outputs();
    check("rs_data", rs_data, m_read(rs_addr));
    check("rt_data", rt_data, m_read(rt_addr));
    check("dump_valid", 32'(dump_valid), 32'(m_valid));
    check("dump_busy", 32'(dump_busy), 32'(m_valid));
    check("dump_done", 32'(dump_done), 32'(m_done));
    if (m_valid) begin
      check("dump_idx", 32'(dump_idx), 32'(m_idx));
      check("dump_data", dump_data, m_data);
    end
  endtask

  // mid: sample at the falling edge; fin: apply the rising edge to the model.
  task automatic mid();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic fin();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    mid();
    fin();
  endtask

  task automatic idle_inputs();
    we = 0; wa = '0; wd = '0; start = 0; ready = 0;
    rs_addr = '0; rt_addr = '0;
  endtask

  task automatic rand_inputs(input int start_pct);
    rs_addr = NbAddr'($urandom_range(NbReg - 1));
    rt_addr = $urandom_range(3) == 0 ? wa : NbAddr'($urandom_range(NbReg - 1));
    we      = $urandom_range(1);
    wa      = NbAddr'($urandom_range(NbReg - 1));
    wd      = $urandom;
    start   = ($urandom_range(99) < start_pct);
    ready   = ($urandom_range(3) != 0);
    if ($urandom_range(2) == 0) rs_addr = wa;
  endtask

  // Runs a started dump to completion with ready high; bounded.
  task automatic drain_dump();
    int guard = 0;
    while ((m_valid || m_done) && guard < 200) begin
      ready = 1;
      start = 0;
      step();
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #2;
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_busy", 32'(dump_busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    check("rst_idx", 32'(dump_idx), 32'd0);
    check("rst_data", dump_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step();

    // Write with same-cycle bypass, then read back from storage.
    we = 1; wa = 5; wd = 32'hDEADBEEF; rs_addr = 5; rt_addr = 6;
    mid();
    check("bypass_rs", rs_data, 32'hDEADBEEF);
    fin();
    we = 0;
    mid();
    check("stored_rs", rs_data, 32'hDEADBEEF);
    fin();

    // r0 is never written.
    we = 1; wa = 0; wd = 32'h12345678; rs_addr = 0; rt_addr = 0;
    mid();
    check("r0_rs_same", rs_data, 32'd0);
    check("r0_rt_same", rt_data, 32'd0);
    fin();
    we = 0;
    mid();
    check("r0_rs_next", rs_data, 32'd0);
    fin();

    // Preload rN = N*0x11.
    for (int n = 1; n < NbReg; n++) begin
      we = 1; wa = NbAddr'(n); wd = 32'(n * 32'h11);
      step();
    end
    we = 0;

    // Full dump with ready held high.
    start = 1; ready = 1;
    step();
    start = 0;
    for (int i = 0; i < NbReg; i++) begin
      mid();
      check("full_valid", 32'(dump_valid), 32'd1);
      check("full_idx", 32'(dump_idx), 32'(i));
      check("full_data", dump_data, 32'(i * 32'h11));
      fin();
    end
    mid();
    check("full_done", 32'(dump_done), 32'd1);
    check("full_busy_low", 32'(dump_busy), 32'd0);
    fin();
    mid();
    check("done_one_cycle", 32'(dump_done), 32'd0);
    fin();

    // Backpressure at idx 7 with concurrent writes and an ignored restart.
    start = 1; ready = 1;
    step();
    start = 0;
    for (int i = 0; i < 7; i++) step();
    ready = 0; we = 1; wa = 7; wd = 32'hAAAA;
    mid();
    check("bp_idx7", 32'(dump_idx), 32'd7);
    fin();
    we = 0; start = 1;
    mid();
    check("bp_hold_data", dump_data, 32'h77);
    fin();
    start = 0; ready = 1; we = 1; wa = 8; wd = 32'hBBBB;
    mid();
    check("bp_hold_idx", 32'(dump_idx), 32'd7);
    fin();
    we = 0;
    mid();
    check("bp_bypass_beat", dump_data, 32'hBBBB);
    fin();
    drain_dump();

    // Reset in the middle of a dump.
    start = 1; ready = 1;
    step();
    start = 0;
    for (int i = 0; i < 12; i++) step();
    rs_addr = 3; rt_addr = 9; we = 0;
    mid();
    check("pre_rst_idx", 32'(dump_idx), 32'd12);
    rst_n = 0;
    #1;
    model_reset();
    check("mid_rst_valid", 32'(dump_valid), 32'd0);
    check("mid_rst_busy", 32'(dump_busy), 32'd0);
    check("mid_rst_idx", 32'(dump_idx), 32'd0);
    check("mid_rst_rs", rs_data, 32'd0);
    check("mid_rst_rt", rt_data, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_done", 32'(dump_done), 32'd0);
    rst_n = 1;
    ready = 1;
    step();
    step();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < NbReg; i++) begin
      mid();
      check("fresh_data", dump_data, 32'd0);
      fin();
    end
    drain_dump();

    // Randomised traffic: writes, reads, restarts and backpressure.
    for (int c = 0; c < 2000; c++) begin
      rand_inputs(10);
      step();
    end
    idle_inputs();
    drain_dump();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
